prog_mem: RTL
=============

# prog_mem

Parametrised, loadable instruction memory that replaces the fixed combinational instruction ROM in front of the basic processor's fetch stage. A program is streamed in through a load port after reset, then the core fetches instructions through a registered request/valid port with stall support. Addresses beyond the loaded program length return the NOP word.

## Interface
- `IW`, default 10: instruction width; 4-bit opcode plus two 3-bit fields at default.
- `AW`, default 8: address width.
- `DEPTH`, default 2**AW: number of storage words; must be ≤ 2**AW.
- `NOP`, default 0: word returned for unloaded or out-of-range addresses.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load_start` input 1: one-cycle pulse that begins a new program load.
- `load_valid` input 1: `load_data` is valid this cycle.
- `load_last` input 1: qualifies the final load word; sampled only with `load_valid`.
- `load_data` input IW: instruction word to store.
- `load_err` output 1: sticky overflow flag; cleared by `load_start` or reset.
- `ready` output 1: high in RUN state only.
- `prog_len` output AW+1: number of words in the loaded program.
- `fetch_req` input 1: fetch request.
- `fetch_addr` input AW: word address of the fetch.
- `fetch_stall` input 1: consumer cannot accept; hold the current output.
- `fetch_valid` output 1: `fetch_inst` is valid.
- `fetch_inst` output IW: fetched instruction.

## Operation
- States are EMPTY, LOAD and RUN. Reset enters EMPTY with these values: `fetch_valid`=0, `fetch_inst`=NOP, `prog_len`=0, `load_err`=0, `ready`=0, write pointer=0.
- `load_start` in any state moves to LOAD, clears the write pointer, `load_err` and `fetch_valid`, and sets `prog_len`=0. It has priority over a `load_valid` or `fetch_req` in the same cycle; those are dropped.
- In LOAD, each `load_valid` writes `mem[ptr]`=`load_data` and increments `ptr`.
- `load_valid` with `load_last` moves to RUN and sets `prog_len`=ptr+1.
- Overflow: `load_valid` with `ptr`==DEPTH does not write, sets `load_err`, and leaves the state unchanged. A following `load_last` still enters RUN with `prog_len`=DEPTH.
- `fetch_req` in EMPTY or LOAD is ignored, and `fetch_valid` stays 0.
- In RUN, an accepted `fetch_req` returns `mem[fetch_addr]` if `fetch_addr` < `prog_len`, else NOP.
- A request is accepted when RUN, `fetch_req` is high, and it is not the case that `fetch_valid` and `fetch_stall` are both high.
- Stall: while `fetch_valid` and `fetch_stall` are both high, `fetch_inst` and `fetch_valid` hold, and new requests are not accepted. The requester must hold its request.
- When no request is accepted and there is no stall, `fetch_valid` drops to 0 and `fetch_inst` holds its last value.
- Memory contents are not cleared by reset. A location is never read unless it is below `prog_len`.

## Timing
- Fetch latency is 1 cycle: a request accepted at edge N gives `fetch_valid`=1 after edge N, with data from the memory state before edge N.
- Back-to-back: one accepted request per cycle, full throughput.
- The load write takes effect at the edge where `load_valid` is sampled.
- `ready` rises in the cycle after the edge that samples `load_last`, so a fetch is accepted no earlier than 1 cycle after the last load beat.
- `rst_n` low mid-load or mid-fetch asynchronously forces the reset values. After release the block is in EMPTY and the program must be reloaded.

## Structure
- The shared package `cpu_pkg` holds the default IW/AW, the NOP encoding, the opcode field positions, and the state enum (EMPTY, LOAD, RUN).
- One sub-module, `prog_mem_ram`: a single-port-write / single-port-read synchronous RAM parametrised by IW and DEPTH.
- The top level holds the FSM, the pointer, the length register, and the output/stall holding logic.

## Test plan
- Reset with no load, then `fetch_req` at address 0 → `fetch_valid` stays 0, `ready`=0, `fetch_inst`=0.
- Load 0x0BE, 0x0B8, 0x048 (last), then fetch addresses 0, 1, 2, 3 back-to-back → valid for 4 cycles with 0x0BE, 0x0B8, 0x048, then NOP; `prog_len`=3.
- Fetch address 1, then hold `fetch_stall` high for 3 cycles with `fetch_addr`=2 → 0x0B8 held for 4 cycles, then 0x048.
- DEPTH=4: load 5 words with the 5th marked last → `load_err`=1, `prog_len`=4, address 3 returns the 4th word.
- `load_start` in RUN during a fetch stream → `fetch_valid`=0 the next cycle and `ready`=0. A reload of 1 word (0x3C0) gives `prog_len`=1, and address 1 returns NOP.
- Assert `rst_n` low for 1 cycle mid-load after 2 beats → all outputs reach reset values immediately; the state is EMPTY after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-format constants and the program-memory state encoding.
// Rev 1.0
`default_nettype none

package cpu_pkg;

  localparam int IW_DEF = 10;
  localparam int AW_DEF = 8;

  localparam logic [IW_DEF-1:0] NOP_WORD = '0;

  // 4-bit opcode over two 3-bit register fields
  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 3;
  localparam int RB_MSB  = 2;
  localparam int RB_LSB  = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } pm_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_mem_ram.sv
// prog_mem_ram: one write port, one registered read port; contents survive reset.
// Rev 1.0
`default_nettype none

module prog_mem_ram #(
  parameter int IW    = 10,
  parameter int DEPTH = 256,
  parameter int RAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [IW-1:0]  wdata,
  input  logic           re,
  input  logic [RAW-1:0] raddr,
  output logic [IW-1:0]  rdata
);

  logic [IW-1:0] mem [DEPTH];

  // Read data only updates on re, so it naturally holds between fetches.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_mem.sv
// prog_mem: loadable instruction memory with a registered, stallable fetch port.
// Rev 1.0
`default_nettype none

module prog_mem
  import cpu_pkg::*;
#(
  parameter int            IW    = IW_DEF,
  parameter int            AW    = AW_DEF,
  parameter int            DEPTH = 2**AW,
  parameter logic [IW-1:0] NOP   = IW'(NOP_WORD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic          load_last,
  input  logic [IW-1:0] load_data,
  output logic          load_err,
  output logic          ready,
  output logic [AW:0]   prog_len,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  input  logic          fetch_stall,
  output logic          fetch_valid,
  output logic [IW-1:0] fetch_inst
);

  localparam int          RAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  pm_state_t     state;
  pm_state_t     state_nx;
  logic [AW:0]   ptr;
  logic          hit;
  logic [IW-1:0] ram_q;

  logic ptr_full;
  logic load_beat;
  logic wr_en;
  logic hold;
  logic in_range;
  logic accept;
  logic rd_en;

  always_comb begin
    ptr_full  = (ptr == DEPTH_W);
    load_beat = (state == LOAD) && load_valid && !load_start;
    wr_en     = load_beat && !ptr_full;
    hold      = fetch_valid && fetch_stall;
    in_range  = ({1'b0, fetch_addr} < prog_len);
    accept    = (state == RUN) && fetch_req && !hold && !load_start;
    rd_en     = accept && in_range;
  end

  always_comb begin
    state_nx = state;
    if (load_start) begin
      state_nx = LOAD;
    end else if (load_beat && load_last) begin
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      prog_len    <= '0;
      load_err    <= 1'b0;
      fetch_valid <= 1'b0;
      hit         <= 1'b0;
    end else if (load_start) begin
      ptr         <= '0;
      prog_len    <= '0;
      load_err    <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      if (load_beat) begin
        if (ptr_full) begin
          load_err <= 1'b1;
        end else begin
          ptr <= ptr + ONE_W;
        end
        if (load_last) begin
          prog_len <= ptr_full ? DEPTH_W : ptr + ONE_W;
        end
      end
      // hit selects between RAM data and NOP for the word currently presented
      if (accept) begin
        fetch_valid <= 1'b1;
        hit         <= in_range;
      end else if (!hold) begin
        fetch_valid <= 1'b0;
      end
    end
  end

  assign ready      = (state == RUN);
  assign fetch_inst = hit ? ram_q : NOP;

  prog_mem_ram #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .RAW   (RAW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ptr[RAW-1:0]),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (fetch_addr[RAW-1:0]),
    .rdata (ram_q)
  );

endmodule

`default_nettype wire
